// File: rtl/risc_prog_loader.sv
// Byte-serial program loader: streams bytes into the CPU instruction port while holding the CPU in reset.
// Optional running checksum of written bytes is enabled by defining LOADER_CHECKSUM_EN.
module risc_prog_loader #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] inst_address,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      inst_we      <= 1'b0;
      inst_address <= '0;
      inst_data    <= '0;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      addr         <= '0;
      remaining    <= '0;
    end else begin
      inst_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          cpu_rst_n <= 1'b1;
          if (start && (length != '0)) begin
            state     <= LOAD;
            addr      <= base_addr;
            remaining <= length;
            aborted   <= 1'b0;
            busy      <= 1'b1;
            cpu_rst_n <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        LOAD: begin
          // Abort takes priority over a coincident transfer: the byte is dropped.
          if (abort) begin
            state     <= IDLE;
            aborted   <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b1;
            in_ready  <= 1'b0;
          end else if (in_valid && in_ready) begin
            state        <= WRITE;
            inst_data    <= in_data;
            inst_address <= addr;
            inst_we      <= 1'b1;
            in_ready     <= 1'b0;
          end
        end
        WRITE: begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          if (abort) begin
            state     <= IDLE;
            aborted   <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b1;
            in_ready  <= 1'b0;
          end else if (remaining == (ADDR_W+1)'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b1;
            in_ready  <= 1'b0;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic launch;
  assign launch = (state == IDLE) && start && (length != '0);

  // Accumulates the byte present on inst_data during its WRITE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (launch) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + inst_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
